qos_dequeue_scheduler: RTL and testbench
========================================

// Module: qos_dequeue_scheduler
// PURPOSE
//  Read-side scheduler for the 4-class QoS queuing datapath. On each read tick it picks one of the four
//  6-deep class buffers using the occupancy-indexed weight table: LLQ when lightly loaded, WFQ when heavy.
//  It pops the selected buffer over a req/ack handshake and presents {class,payload} plus statistics.
//  Sits between the four class buffers and the output display/counter logic.
// PARAMETERS
//  DEPTH        6   entries per class buffer; occupancy range 0..DEPTH
//  OCC_W        3   occupancy width per queue
//  PAYLOAD_W    2   payload bits per entry
//  CNT_W        10  statistics counter width
//  ACK_TIMEOUT  15  clk cycles to wait for deq_ack before abort
//  STARVE_LIMIT 8   consecutive grants a non-empty queue may be skipped (guard build only)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            synchronous, active-high
//  enable       in   1            0: ignore ticks; finish any in-flight transfer
//  rd_tick      in   1            slow read clock from button/divider, asynchronous; rising edge = one read request
//  occ          in   4*OCC_W      occupancy, queue q at [q*OCC_W +: OCC_W]; q0 = class 2'b00
//  deq_req      out  4            one-hot pop request to class buffer
//  deq_ack      in   1            buffer popped head; deq_data valid this cycle
//  deq_data     in   PAYLOAD_W    head payload of granted queue
//  out_valid    out  1            1-cycle pulse: out_data updated
//  out_data     out  2+PAYLOAD_W  {class id, payload}; holds last value
//  ct_received  out  CNT_W        completed dequeues, saturating
//  ct_empty     out  CNT_W        ticks with all queues empty, saturating
//  ack_err      out  1            sticky: ack timeout occurred; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; deq_req=0, out_valid=0, out_data=0, counters=0, ack_err=0, pending=0, aging=0.
//  rd_tick: 2-FF synchronizer, then rising-edge detect -> tick (1 clk). tick with enable=0 is discarded.
//  Weight per queue w[q] = LUT[q][occ_q]; occ_q > DEPTH treated as DEPTH.
//   q0: 0,9,13,15,16,17,19   q1: 0,6,8,12,14,18,21
//   q2: 0,3,5,7,11,19,23     q3: 0,1,2,4,10,22,24
//   Override: occ2==5 && occ0==6 -> (occ1<5 ? w0=20 : w2=20).
//  Winner: max weight among queues with occ>0; ties -> lowest index. All empty -> no winner.
//  FSM:
//   IDLE   : tick or pending -> DECIDE, clear pending.
//   DECIDE : snapshot occ, register weights and winner (1 cycle). No winner -> ct_empty++, IDLE.
//            Else -> GRANT.
//   GRANT  : deq_req=onehot(winner), held stable; timeout counter runs.
//            deq_ack -> capture {winner,deq_data}, deq_req=0 next cycle, -> DONE.
//            ACK_TIMEOUT cycles without ack -> ack_err=1, deq_req=0, -> IDLE; no counter change.
//   DONE   : out_data updated, out_valid=1, ct_received++, -> IDLE.
//  Latency: tick to deq_req = 2 clk; deq_ack to out_valid = 1 clk.
//  Tick while not IDLE: set pending (1-deep); further ticks while pending set are dropped.
//  deq_ack outside GRANT: ignored. Counters saturate at all-ones.
//  enable falling mid-transfer: transfer completes; pending cleared.
//  reset mid-transfer: deq_req low the cycle after reset is sampled; in-flight data discarded.
// CONFIGURATION
//  QOS_STARVATION_GUARD_EN defined: per-queue aging counter, incremented when queue non-empty and not
//   granted in DECIDE, cleared on grant or empty. Any aging >= STARVE_LIMIT forces that queue (lowest
//   index among aged) over the weight winner.
//  Undefined: no aging logic; selection purely from weight table.
// STRUCTURE
//  qos_pkg: NUM_Q=4, DEPTH, weight LUT constant array, qid_t (2-bit), state enum, onehot function.
//  Sub-module qos_weight_lut: combinational occ[4] -> weight[4], including override rule.
//  Top holds synchronizer, FSM, timeout, counters, aging.
// TESTING
//  occ={0,0,0,0}, tick -> no deq_req; ct_empty=1; out_valid stays 0.
//  occ q0=1,q3=3, tick -> deq_req=0001 at +2 clk; ack with data 2'b10 -> out_data=4'b0010, ct_received=1.
//  occ q0=6,q1=2,q2=5,q3=0 -> override w0=20 vs w2=19 -> grant q0; with q1=5 -> w2=20 vs w1=18 -> grant q2.
//  occ q3=5,q2=4 (w 22 vs 11) -> grant 1000; withhold ack 15 clk -> deq_req drops, ack_err=1.
//  Two ticks during GRANT -> exactly one extra DECIDE after DONE; third tick dropped.
//  Guard build: q3=6 held, q0=1 held, ack every grant -> q0 granted on 9th DECIDE; non-guard never.

Source files
------------

// File: rtl/qos_dequeue_scheduler_pkg.sv
// Shared constants, types and the occupancy-indexed weight table for the QoS read-side scheduler.
package qos_dequeue_scheduler_pkg;

    localparam int NUM_Q        = 4;
    localparam int DEPTH        = 6;
    localparam int OCC_W        = 3;
    localparam int PAYLOAD_W    = 2;
    localparam int CNT_W        = 10;
    localparam int ACK_TIMEOUT  = 15;
    localparam int STARVE_LIMIT = 8;
    localparam int WGT_W        = 5;
    localparam int TCNT_W       = $clog2(ACK_TIMEOUT);
    localparam int AGE_W        = $clog2(STARVE_LIMIT + 1);

    typedef logic [1:0]       qid_t;
    typedef logic [WGT_W-1:0] wgt_t;

    typedef enum logic [1:0] {IDLE, DECIDE, GRANT, DONE} state_t;

    // Row = queue, column = occupancy 0..DEPTH; low occupancy favours q0 (LLQ), deep queues win later.
    localparam wgt_t WEIGHT_LUT [NUM_Q][DEPTH+1] = '{
        '{5'd0, 5'd9, 5'd13, 5'd15, 5'd16, 5'd17, 5'd19},
        '{5'd0, 5'd6, 5'd8,  5'd12, 5'd14, 5'd18, 5'd21},
        '{5'd0, 5'd3, 5'd5,  5'd7,  5'd11, 5'd19, 5'd23},
        '{5'd0, 5'd1, 5'd2,  5'd4,  5'd10, 5'd22, 5'd24}
    };

    localparam wgt_t OVERRIDE_WGT = 5'd20;

    function automatic logic [NUM_Q-1:0] onehot(input qid_t q);
        logic [NUM_Q-1:0] r;
        r    = '0;
        r[q] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/qos_dequeue_scheduler_if.sv
// Pop handshake between the scheduler (master) and the four class buffers (slave).
interface qos_dequeue_scheduler_if;

    logic [qos_dequeue_scheduler_pkg::NUM_Q-1:0]     deq_req;
    logic                                            deq_ack;
    logic [qos_dequeue_scheduler_pkg::PAYLOAD_W-1:0] deq_data;

    modport master (output deq_req, input deq_ack, input deq_data);
    modport slave  (input deq_req, output deq_ack, output deq_data);

endinterface

// File: rtl/qos_dequeue_scheduler_weight_lut.sv
// Combinational occupancy -> weight lookup for all queues, including the q0/q2 override rule.
module qos_weight_lut
    import qos_dequeue_scheduler_pkg::*;
(
    input  logic [NUM_Q-1:0][OCC_W-1:0] occ,
    output logic [NUM_Q-1:0][WGT_W-1:0] weight
);

    logic [NUM_Q-1:0][OCC_W-1:0] occ_c;

    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            occ_c[q]  = (occ[q] > OCC_W'(DEPTH)) ? OCC_W'(DEPTH) : occ[q];
            weight[q] = WEIGHT_LUT[q][occ_c[q]];
        end
        // A full q0 alongside a nearly-full q2 gets a tie-breaking boost on one of them.
        if (occ_c[2] == OCC_W'(5) && occ_c[0] == OCC_W'(DEPTH)) begin
            if (occ_c[1] < OCC_W'(5)) weight[0] = OVERRIDE_WGT;
            else                      weight[2] = OVERRIDE_WGT;
        end
    end

endmodule

// File: rtl/qos_dequeue_scheduler.sv
// Read-side QoS dequeue scheduler: tick sync, weight-based queue pick, pop handshake, stats.
// Optional build macro QOS_STARVATION_GUARD_EN adds per-queue aging that overrides the weight winner.
module qos_dequeue_scheduler
    import qos_dequeue_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       rd_tick,
    input  logic [NUM_Q*OCC_W-1:0]     occ,
    qos_dequeue_scheduler_if.master    deq,
    output logic                       out_valid,
    output logic [1+PAYLOAD_W:0]       out_data,
    output logic [CNT_W-1:0]           ct_received,
    output logic [CNT_W-1:0]           ct_empty,
    output logic                       ack_err
);

    state_t                      state;
    logic [2:0]                  sync;
    logic                        tick;
    logic                        pending;
    logic [TCNT_W-1:0]           tcnt;
    qid_t                        win_r;
    logic [NUM_Q-1:0][OCC_W-1:0] occ_q;
    logic [NUM_Q-1:0][WGT_W-1:0] wgt;
    logic                        has_win;
    qid_t                        win_q;
    qid_t                        sel_q;
    wgt_t                        best;

    assign occ_q = occ;

    // rd_tick is asynchronous: two flops to settle, third for edge detect.
    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[1:0], rd_tick};
    end

    assign tick = sync[1] & ~sync[2];

    qos_weight_lut u_lut (
        .occ    (occ_q),
        .weight (wgt)
    );

    always_comb begin
        has_win = 1'b0;
        win_q   = '0;
        best    = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (occ_q[q] != '0 && (!has_win || wgt[q] > best)) begin
                has_win = 1'b1;
                win_q   = qid_t'(q);
                best    = wgt[q];
            end
        end
    end

`ifdef QOS_STARVATION_GUARD_EN
    logic [NUM_Q-1:0][AGE_W-1:0] aging;

    // Downward scan leaves the lowest-index aged, still non-empty queue selected.
    always_comb begin
        sel_q = win_q;
        for (int q = NUM_Q - 1; q >= 0; q--) begin
            if (aging[q] >= AGE_W'(STARVE_LIMIT) && occ_q[q] != '0) sel_q = qid_t'(q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aging <= '0;
        end else if (state == DECIDE) begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (occ_q[q] == '0 || (has_win && sel_q == qid_t'(q)))
                    aging[q] <= '0;
                else if (aging[q] < AGE_W'(STARVE_LIMIT))
                    aging[q] <= aging[q] + 1'b1;
            end
        end
    end
`else
    assign sel_q = win_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            deq.deq_req <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            ct_received <= '0;
            ct_empty    <= '0;
            ack_err     <= 1'b0;
            pending     <= 1'b0;
            tcnt        <= '0;
            win_r       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (!enable)                     pending <= 1'b0;
            else if (tick && state != IDLE)  pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable && (tick || pending)) begin
                        state   <= DECIDE;
                        pending <= 1'b0;
                    end
                end
                DECIDE: begin
                    if (!has_win) begin
                        if (ct_empty != '1) ct_empty <= ct_empty + 1'b1;
                        state <= IDLE;
                    end else begin
                        win_r       <= sel_q;
                        deq.deq_req <= onehot(sel_q);
                        tcnt        <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (deq.deq_ack) begin
                        out_data    <= {win_r, deq.deq_data};
                        out_valid   <= 1'b1;
                        deq.deq_req <= '0;
                        state       <= DONE;
                    end else if (tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
                        ack_err     <= 1'b1;
                        deq.deq_req <= '0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (ct_received != '1) ct_received <= ct_received + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qos_dequeue_scheduler.sv
// Directed plus randomized bench for qos_dequeue_scheduler against an arithmetic reference model.
module tb_qos_dequeue_scheduler;
    import qos_dequeue_scheduler_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset, enable, rd_tick;
    logic [NUM_Q*OCC_W-1:0] occ;
    logic                   out_valid;
    logic [1+PAYLOAD_W:0]   out_data;
    logic [CNT_W-1:0]       ct_received, ct_empty;
    logic                   ack_err;

    qos_dequeue_scheduler_if bus ();

    qos_dequeue_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rd_tick     (rd_tick),
        .occ         (occ),
        .deq         (bus),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .ct_received (ct_received),
        .ct_empty    (ct_empty),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int exp_recv = 0, exp_empty = 0;
    int age [4];
    int last_grant = 0;
    int lut [4][7] = '{
        '{0, 9, 13, 15, 16, 17, 19},
        '{0, 6, 8, 12, 14, 18, 21},
        '{0, 3, 5, 7, 11, 19, 23},
        '{0, 1, 2, 4, 10, 22, 24}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input int a0, input int a1, input int a2, input int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Reference decision: returns winning queue or -1, and advances the aging model.
    function automatic int model_decide(input logic [11:0] o);
        int oc[4];
        int w[4];
        int win, best;
        win = -1;
        best = -1;
        for (int q = 0; q < 4; q++) begin
            oc[q] = int'(o[q*3 +: 3]);
            if (oc[q] > 6) oc[q] = 6;
            w[q] = lut[q][oc[q]];
        end
        if (oc[2] == 5 && oc[0] == 6) begin
            if (oc[1] < 5) w[0] = 20;
            else           w[2] = 20;
        end
        for (int q = 0; q < 4; q++)
            if (oc[q] > 0 && w[q] > best) begin best = w[q]; win = q; end
`ifdef QOS_STARVATION_GUARD_EN
        begin
            int forced;
            forced = -1;
            for (int q = 3; q >= 0; q--)
                if (age[q] >= 8 && oc[q] > 0) forced = q;
            if (forced >= 0) win = forced;
            for (int q = 0; q < 4; q++) begin
                if (oc[q] == 0 || q == win) age[q] = 0;
                else if (age[q] < 8)        age[q] = age[q] + 1;
            end
        end
`endif
        return win;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        rd_tick = 1'b1;
        repeat (3) step();
        rd_tick = 1'b0;
    endtask

    task automatic wait_req();
        int cyc;
        cyc = 0;
        while (bus.deq_req == '0 && cyc < 12) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_ack(input string tag, input int win, input logic [1:0] d);
        logic [3:0] exp_od;
        exp_od = {2'(win), d};
        bus.deq_ack  = 1'b1;
        bus.deq_data = d;
        step();
        bus.deq_ack = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " out_data"}, 32'(out_data), 32'(exp_od));
        step();
        exp_recv++;
        check({tag, " ct_received"}, 32'(ct_received), 32'(exp_recv));
        check({tag, " out_valid pulse"}, 32'(out_valid), 32'd0);
    endtask

    task automatic transact(input string tag, input logic [11:0] o, input int dly, input logic [1:0] d);
        int win;
        logic [3:0] exp_oh;
        bit saw;
        win = model_decide(o);
        occ = o;
        tick_pulse();
        if (win < 0) begin
            saw = 1'b0;
            repeat (6) begin
                if (bus.deq_req != '0 || out_valid) saw = 1'b1;
                step();
            end
            exp_empty++;
            check({tag, " empty quiet"}, 32'(saw), 32'd0);
            check({tag, " ct_empty"}, 32'(ct_empty), 32'(exp_empty));
        end else begin
            wait_req();
            exp_oh = '0;
            exp_oh[win] = 1'b1;
            last_grant = int'(bus.deq_req);
            check({tag, " grant"}, 32'(bus.deq_req), 32'(exp_oh));
            if (bus.deq_req == '0) return;
            repeat (dly) step();
            do_ack(tag, win, d);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, win;
        bit saw;
        logic [11:0] o;
        logic [3:0]  exp9;
        for (int q = 0; q < 4; q++) age[q] = 0;
        reset = 1'b1; enable = 1'b1; rd_tick = 1'b0; occ = '0;
        bus.deq_ack = 1'b0; bus.deq_data = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst deq_req", 32'(bus.deq_req), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst ct_received", 32'(ct_received), 32'd0);
        check("rst ct_empty", 32'(ct_empty), 32'd0);
        check("rst ack_err", 32'(ack_err), 32'd0);

        transact("all empty", mk(0, 0, 0, 0), 0, 2'b00);
        transact("q0 vs q3", mk(1, 0, 0, 3), 1, 2'b10);
        transact("override q0", mk(6, 2, 5, 0), 0, 2'b01);
        transact("override q2", mk(6, 5, 5, 0), 2, 2'b11);

        // Withheld ack: request must drop after the timeout and flag the sticky error.
        o = mk(0, 0, 4, 5);
        win = model_decide(o);
        occ = o;
        tick_pulse();
        wait_req();
        check("timeout grant", 32'(bus.deq_req), 32'(1 << win));
        n = 0;
        while (bus.deq_req != '0 && n < 30) begin step(); n++; end
        check("timeout req cycles", 32'(n), 32'd15);
        check("timeout ack_err", 32'(ack_err), 32'd1);
        check("timeout ct_received", 32'(ct_received), 32'(exp_recv));

        // Two ticks during GRANT -> one pending decision, the second tick is dropped.
        o = mk(2, 0, 0, 0);
        win = model_decide(o);
        occ = o;
        tick_pulse();
        wait_req();
        check("pend grant1", 32'(bus.deq_req), 32'(1 << win));
        tick_pulse(); repeat (3) step();
        tick_pulse(); repeat (3) step();
        do_ack("pend ack1", win, 2'b01);
        win = model_decide(o);
        wait_req();
        check("pend grant2", 32'(bus.deq_req), 32'(1 << win));
        do_ack("pend ack2", win, 2'b10);
        saw = 1'b0;
        repeat (20) begin
            if (bus.deq_req != '0) saw = 1'b1;
            step();
        end
        check("pend no third", 32'(saw), 32'd0);

        // Disabled ticks are discarded entirely.
        enable = 1'b0;
        occ = mk(3, 0, 0, 0);
        tick_pulse();
        saw = 1'b0;
        repeat (8) begin
            if (bus.deq_req != '0) saw = 1'b1;
            step();
        end
        enable = 1'b1;
        repeat (3) step();
        check("disabled tick", 32'(saw), 32'd0);
        check("disabled ct_empty", 32'(ct_empty), 32'(exp_empty));

        // Fresh start for the aging scenario; ack_err must clear too.
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        exp_recv = 0; exp_empty = 0;
        for (int q = 0; q < 4; q++) age[q] = 0;
        check("rst2 ack_err", 32'(ack_err), 32'd0);
        check("rst2 ct_received", 32'(ct_received), 32'd0);
        for (int i = 1; i <= 9; i++)
            transact($sformatf("starve %0d", i), mk(1, 0, 0, 6), 0, 2'(i));
`ifdef QOS_STARVATION_GUARD_EN
        exp9 = 4'b0001;
`else
        exp9 = 4'b1000;
`endif
        check("starve 9th grant", 32'(last_grant), 32'(exp9));

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) o = '0;
            else o = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            transact($sformatf("rand %0d", i), o, $urandom_range(0, 4), 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
